// File: rtl/calc_pkg.sv
// Shared opcode, flag-index and state definitions for the sequential calculator.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NOT  = 3'b010,
        OP_XOR  = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_MULT = 3'b110,
        OP_DIV  = 3'b111
    } op_e;

    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_OVF   = 2;
    localparam int unsigned FLAG_DBZ   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // MULT always iterates; DIV iterates only with a non-zero divisor.
    function automatic logic needs_iter(input op_e op, input logic b_is_zero);
        return (op == OP_MULT) || ((op == OP_DIV) && !b_is_zero);
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// The first iteration runs on the start edge directly from the a/b inputs.
module seq_muldiv
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             div_q, div_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   src_hi;
    logic [WIDTH-1:0] src_lo;
    logic [WIDTH-1:0] src_b;
    logic             src_div;
    logic [WIDTH:0]   mul_add;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [CW-1:0]    cnt_inc;

    always_comb begin
        src_hi  = start ? '0     : hi_q;
        src_lo  = start ? a      : lo_q;
        src_b   = start ? b      : opb_q;
        src_div = start ? is_div : div_q;

        mul_add   = src_lo[0] ? (src_hi + {1'b0, src_b}) : src_hi;
        div_shift = {src_hi[WIDTH-1:0], src_lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, src_b};
        div_ge    = !div_trial[WIDTH];
        cnt_inc   = cnt_q + CW'(1);

        hi_d   = hi_q;
        lo_d   = lo_q;
        opb_d  = opb_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (start || busy_q) begin
            if (src_div) begin
                hi_d = {1'b0, div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]};
                lo_d = {src_lo[WIDTH-2:0], div_ge};
            end else begin
                hi_d = {1'b0, mul_add[WIDTH:1]};
                lo_d = {mul_add[0], src_lo[WIDTH-1:1]};
            end
            opb_d = src_b;
            div_d = src_div;
        end

        if (start) begin
            cnt_d  = CW'(1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(WIDTH)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opb_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opb_q  <= opb_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            div_q  <= div_d;
            done_q <= done_d;
        end
    end

    assign done      = done_q;
    assign product   = {hi_q[WIDTH-1:0], lo_q};
    assign quotient  = lo_q;
    assign remainder = hi_q[WIDTH-1:0];

endmodule

// File: rtl/seq_calculator.sv
// Single-request calculator: logic/ADD/SUB in one cycle, MULT/DIV via seq_muldiv,
// result held in DONE until the consumer handshakes.
module seq_calculator
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic [3:0]         flags
);

    state_e state_q, state_d;
    op_e    op_q, op_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [3:0]         flags_q, flags_d;

    op_e                op_in;
    logic               accept;
    logic               b_zero;
    logic               iter_op;
    logic [WIDTH:0]     sum_add;
    logic [WIDTH:0]     sum_sub;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;
    logic               alu_dbz;
    logic [2*WIDTH-1:0] md_res;

    logic               md_done;
    logic [2*WIDTH-1:0] md_product;
    logic [WIDTH-1:0]   md_quotient;
    logic [WIDTH-1:0]   md_remainder;

    assign op_in   = op_e'(op);
    assign b_zero  = (b == '0);
    assign iter_op = needs_iter(op_in, b_zero);

    seq_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && iter_op),
        .is_div    (op_in == OP_DIV),
        .a         (a),
        .b         (b),
        .done      (md_done),
        .product   (md_product),
        .quotient  (md_quotient),
        .remainder (md_remainder)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = iter_op ? ST_BUSY : ST_DONE;
            ST_BUSY: if (md_done) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; in_ready is gated so it stays low while reset is held
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !rst;
        out_valid = (state_q == ST_DONE);
        accept    = in_valid && in_ready;
    end

    // Single-cycle datapath for logic, ADD, SUB and DIV-by-zero
    always_comb begin
        sum_add   = {1'b0, a} + {1'b0, b};
        sum_sub   = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_dbz   = 1'b0;
        unique case (op_in)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NOT:  alu_res = ~a;
            OP_XOR:  alu_res = a ^ b;
            OP_ADD: begin
                alu_res   = sum_add[WIDTH-1:0];
                alu_carry = sum_add[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = sum_sub[WIDTH-1:0];
                alu_carry = sum_sub[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_DIV: begin
                alu_res = '1;
                alu_dbz = 1'b1;
            end
            default: alu_res = '0;
        endcase
    end

    // Result/flag capture: on acceptance for single-cycle ops, on md_done otherwise
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        op_d     = op_q;
        md_res   = (op_q == OP_DIV) ? {md_remainder, md_quotient} : md_product;

        if (accept) begin
            op_d = op_in;
            if (!iter_op) begin
                result_d = (op_in == OP_DIV) ? {a, alu_res} : {{WIDTH{1'b0}}, alu_res};
                flags_d  = '0;
                flags_d[FLAG_CARRY] = alu_carry;
                flags_d[FLAG_OVF]   = alu_ovf;
                flags_d[FLAG_DBZ]   = alu_dbz;
                flags_d[FLAG_ZERO]  = (result_d == '0);
            end
        end else if ((state_q == ST_BUSY) && md_done) begin
            result_d = md_res;
            flags_d  = '0;
            flags_d[FLAG_OVF]  = (op_q == OP_MULT) && (md_res[2*WIDTH-1:WIDTH] != '0);
            flags_d[FLAG_ZERO] = (md_res == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
            op_q     <= OP_AND;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            op_q     <= op_d;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_seq_calculator.sv
// Directed self-checking bench for seq_calculator at WIDTH=8.
module tb_seq_calculator;

    localparam int unsigned WIDTH = 8;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2:0]         op;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;
    logic [3:0]         flags;

    int checks = 0;
    int errors = 0;

    seq_calculator #(
        .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, check latency/result/flags, optionally stall the
    // consumer for `hold` cycles, then handshake and check return to IDLE.
    // Garbage operands with in_valid=1 are driven while the op is in flight.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [7:0] av,
                         input logic [7:0] bv, input int exp_lat, input logic [15:0] exp_res,
                         input logic [3:0] exp_fl, input int hold);
        int lat;
        out_ready = 1'b0;
        op = o; a = av; b = bv; in_valid = 1'b1;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        a = ~av; b = bv ^ 8'h5A; op = o ^ 3'b001;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, 32'(result), 32'(exp_res));
        check({tag, " flags"}, 32'(flags), 32'(exp_fl));
        check({tag, " busy in_ready"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold result"}, 32'(result), 32'(exp_res));
            check({tag, " hold flags"}, 32'(flags), 32'(exp_fl));
            check({tag, " hold valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " post valid"}, 32'(out_valid), 32'd0);
        check({tag, " post in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int stray;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;
        #1;
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset flags", 32'(flags), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        //    tag       op      a      b     lat  result     {dbz,ovf,c,z} hold
        do_op("add_ff", 3'b100, 8'hFF, 8'h01, 1, 16'h0000, 4'b0011, 0);
        do_op("sub_80", 3'b101, 8'h80, 8'h01, 1, 16'h007F, 4'b0110, 0);
        do_op("sub_01", 3'b101, 8'h01, 8'h02, 1, 16'h00FF, 4'b0000, 0);
        do_op("add_7f", 3'b100, 8'h7F, 8'h01, 1, 16'h0080, 4'b0100, 0);
        do_op("and",    3'b000, 8'hF0, 8'h3C, 1, 16'h0030, 4'b0000, 0);
        do_op("and_z",  3'b000, 8'h0F, 8'hF0, 1, 16'h0000, 4'b0001, 0);
        do_op("or",     3'b001, 8'hA0, 8'h05, 1, 16'h00A5, 4'b0000, 0);
        do_op("not",    3'b010, 8'h0F, 8'h77, 1, 16'h00F0, 4'b0000, 0);
        do_op("mul_ff", 3'b110, 8'hFF, 8'hFF, 9, 16'hFE01, 4'b0100, 0);
        do_op("mul_0",  3'b110, 8'h00, 8'h37, 9, 16'h0000, 4'b0001, 0);
        do_op("div_64", 3'b111, 8'h64, 8'h07, 9, 16'h020E, 4'b0000, 0);
        do_op("div_07", 3'b111, 8'h07, 8'h09, 9, 16'h0700, 4'b0000, 0);
        do_op("div_0n", 3'b111, 8'h00, 8'h05, 9, 16'h0000, 4'b0001, 0);
        do_op("div_z",  3'b111, 8'h2A, 8'h00, 1, 16'h2AFF, 4'b1000, 0);
        do_op("xor_bp", 3'b011, 8'hA5, 8'h0F, 1, 16'h00AA, 4'b0000, 5);

        // Reset four cycles into a multiply
        op = 3'b110; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst result", 32'(result), 32'd0);
        check("midrst flags", 32'(flags), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        stray = 0;
        repeat (WIDTH + 4) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
        end
        out_ready = 1'b0;
        check("midrst no stray", 32'(stray), 32'd0);
        do_op("mul_rst", 3'b110, 8'h0C, 8'h0D, 9, 16'h009C, 4'b0000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_calculator.md
SEQ_CALCULATOR -- requirements
Module: seq_calculator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request present on a/b/op.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port a  input  WIDTH  operand A; the operation is always A op B.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port op  input  3  000 AND, 001 OR, 010 NOT(A), 011 XOR, 100 ADD, 101 SUB, 110 MULT, 111 DIV.
REQ-009 SHALL have port out_valid  output  1  result/flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  2*WIDTH  registered result.
REQ-012 SHALL have port flags  output  4  {div_by_zero, overflow, carry, zero}.

Function
REQ-013 SHALL accept a request in a cycle where in_valid and in_ready are both 1, capturing a, b and op.
REQ-014 SHALL drive in_ready = 1 only in state IDLE; the block holds one request at a time.
REQ-015 SHALL implement states IDLE, BUSY, DONE: IDLE->DONE on accepting op 000-101; IDLE->BUSY on accepting MULT, or DIV with b!=0; IDLE->DONE on accepting DIV with b==0; BUSY->DONE when the iteration count reaches WIDTH; DONE->IDLE when out_ready=1.
REQ-016 SHALL give logic, ADD and SUB a latency of 1: out_valid rises in the cycle after acceptance.
REQ-017 SHALL compute MULT iteratively (shift-add, one bit per cycle) with out_valid rising exactly WIDTH+1 cycles after acceptance; result = full unsigned 2*WIDTH product.
REQ-018 SHALL compute DIV with b!=0 iteratively (restoring, one quotient bit per cycle) with latency WIDTH+1; result[WIDTH-1:0] = unsigned quotient, result[2*WIDTH-1:WIDTH] = remainder.
REQ-019 SHALL, for DIV with b==0, use latency 1, set quotient to all ones, remainder to a, and div_by_zero to 1.
REQ-020 SHALL zero-extend logic, ADD and SUB results to 2*WIDTH; ADD/SUB wrap modulo 2^WIDTH.
REQ-021 SHALL compute SUB as a + ~b + 1; carry = carry-out of WIDTH-bit add (for SUB: 1 = no borrow).
REQ-022 SHALL set overflow to two's-complement signed overflow for ADD/SUB, and to 1 for MULT when result[2*WIDTH-1:WIDTH] != 0; 0 otherwise.
REQ-023 SHALL set zero = 1 iff result == 0; carry = 0 for every op other than ADD/SUB; div_by_zero = 0 for every op other than DIV.
REQ-024 SHALL hold result and flags stable while out_valid=1 and out_ready=0 (DONE backpressure, no timeout).
REQ-025 SHALL return to IDLE, with out_valid low, in the cycle after the DONE handshake; back-to-back throughput is one request per (latency+1) cycles.
REQ-026 SHALL ignore in_valid while not in IDLE; operand changes during BUSY do not affect the result.

Reset
REQ-027 SHALL, on rst=1 at any time including mid-operation, immediately force state IDLE, out_valid=0, result=0, flags=0, iteration count=0; in_ready=0 while rst is held.
REQ-028 SHALL discard any in-flight operation on reset; no result is emitted for it.

Structure
REQ-029 SHALL take opcode constants, the flag bit indices and the state encoding from shared package calc_pkg.
REQ-030 SHALL place the iterative multiply/divide datapath in one sub-module seq_muldiv (start, is_div, a, b -> done, product/quotient/remainder); logic/ADD/SUB remain in the top level.

Verification (WIDTH=8)
REQ-031 SHALL cover ADD a=0xFF b=0x01 -> out_valid 1 cycle after accept, result=0x0000, flags zero=1, carry=1, overflow=0.
REQ-032 SHALL cover SUB a=0x80 b=0x01 -> result=0x007F, carry=1, overflow=1; then SUB a=0x01 b=0x02 -> result=0x00FF, carry=0.
REQ-033 SHALL cover MULT a=0xFF b=0xFF -> out_valid exactly 9 cycles after accept, result=0xFE01, overflow=1.
REQ-034 SHALL cover DIV a=0x64 b=0x07 -> latency 9, result=0x020E (rem 2, quot 14); DIV a=0x2A b=0x00 -> latency 1, result=0x2AFF, div_by_zero=1.
REQ-035 SHALL cover backpressure: hold out_ready=0 for 5 cycles on XOR 0xA5^0x0F -> result 0x00AA stable, in_ready=0 throughout, IDLE one cycle after out_ready=1.
REQ-036 SHALL cover assertion of rst 4 cycles into a MULT -> out_valid=0, result=0 immediately; next request after release completes correctly.
